uart_baud_generator: RTL and testbench



---
 rtl/uart_baud_pkg.sv | 31 +++
 rtl/uart_baud_generator_if.sv | 12 +
 rtl/baud_div_counter.sv | 34 +++
 rtl/uart_baud_generator.sv | 75 +++++++
 tb/tb_uart_baud_generator.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_baud_pkg.sv
// Shared definitions for the UART baud-tick generator: rate codes,
// the standard baud table and the elaboration-time divisor calculation.
package uart_baud_pkg;

  typedef enum logic [2:0] {
    BAUD_2400   = 3'b000,
    BAUD_4800   = 3'b001,
    BAUD_9600   = 3'b010,
    BAUD_19200  = 3'b011,
    BAUD_38400  = 3'b100,
    BAUD_57600  = 3'b101,
    BAUD_115200 = 3'b110,
    BAUD_230400 = 3'b111
  } baud_sel_e;

  localparam int unsigned BAUD_RATES [8] = '{
    2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400
  };

  localparam int DEF_DIV_W = 16;

  // round(clk_hz / (ovs * baud)) with exact halves rounding up
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned ovs,
                                           input int unsigned baud);
    longint unsigned den;
    den = 64'(ovs) * 64'(baud);
    return 32'((64'(clk_hz) * 64'd2 + den) / (den * 64'd2));
  endfunction

endpackage

// File: rtl/uart_baud_generator_if.sv
// Rate-select / baud-strobe bundle between the UART engines and the
// baud-tick generator.
interface uart_baud_generator_if;
  import uart_baud_pkg::*;

  baud_sel_e baudrate;
  logic      bclk;

  modport master (output baudrate, input bclk);
  modport slave  (input baudrate, output bclk);

endinterface

// File: rtl/baud_div_counter.sv
// Generic modulo-D counter with synchronous clear and a wrap strobe.
// The count value is exported only when BAUD_BCLK_SQUARE_EN is defined.
module baud_div_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
`ifdef BAUD_BCLK_SQUARE_EN
  output logic [DIV_W-1:0] o_cnt,
`endif
  output logic             o_wrap
);

  logic [DIV_W-1:0] r_cnt;

  // Any count at or beyond D-1 wraps, so an upset counter recovers in one cycle.
  assign o_wrap = (r_cnt >= (i_div - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (o_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

`ifdef BAUD_BCLK_SQUARE_EN
  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/uart_baud_generator.sv
// Programmable 16x baud-tick generator: selects a divisor from the rate code and
// emits a one-cycle bclk strobe (or a square level with BAUD_BCLK_SQUARE_EN).
module uart_baud_generator
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int          DIV_W       = DEF_DIV_W
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_baud_generator_if.slave  baud_if
);

  baud_sel_e        r_sel;
  logic             r_bclk;
  logic [DIV_W-1:0] w_div_tab [8];
  logic [DIV_W-1:0] w_div;
  logic             w_change;
  logic             w_wrap;
  logic             w_bclk_nxt;

  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    localparam int unsigned DIV_I = calc_div(CLK_FREQ_HZ, OVERSAMPLE, BAUD_RATES[gi]);
    assign w_div_tab[gi] = DIV_W'(DIV_I);
  end

  assign w_div    = w_div_tab[r_sel];
  assign w_change = (baud_if.baudrate != r_sel);

  // Select register: reloaded from the input every cycle, reset included.
  always_ff @(posedge clk) begin
    r_sel <= baud_if.baudrate;
  end

  // Reset and rate change both restart the period from zero.
`ifdef BAUD_BCLK_SQUARE_EN
  logic [DIV_W-1:0] w_cnt;
  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W-1:0] w_half;

  baud_div_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk    (clk),
    .i_clr  (reset | w_change),
    .i_div  (w_div),
    .o_cnt  (w_cnt),
    .o_wrap (w_wrap)
  );

  assign w_half     = (w_div >> 1) + DIV_W'(w_div[0]);
  assign w_cnt_inc  = w_cnt + DIV_W'(1);
  assign w_bclk_nxt = ~w_change & (w_wrap | (w_cnt_inc < w_half));
`else
  baud_div_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk    (clk),
    .i_clr  (reset | w_change),
    .i_div  (w_div),
    .o_wrap (w_wrap)
  );

  assign w_bclk_nxt = ~w_change & w_wrap;
`endif

  // Output register: bclk reflects the counter value it will hold after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk <= 1'b0;
    end else begin
      r_bclk <= w_bclk_nxt;
    end
  end

  assign baud_if.bclk = r_bclk;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Bench for uart_baud_generator: per-cycle reference model plus directed
// period/latency checks and a randomized rate/reset phase.
module tb_uart_baud_generator;
  import uart_baud_pkg::*;

  localparam int CLK_HZ = 100_000_000;
  localparam int OVS    = 16;
  localparam int RATES [8] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400};
  localparam int LIT_D [8] = '{2604, 1302, 651, 326, 163, 109, 54, 27};

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_baud_generator_if bif ();

  uart_baud_generator #(
    .CLK_FREQ_HZ (CLK_HZ),
    .OVERSAMPLE  (OVS),
    .DIV_W       (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .baud_if (bif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int div_of(input logic [2:0] c);
    int den;
    den = OVS * RATES[c];
    return (2 * CLK_HZ + den) / (2 * den);
  endfunction

  // Reference model: edges since the last restart (reset or rate change)
  int         since   = 0;
  int         cur_d   = 1;
  logic [2:0] prev_sel = '0;
  logic [2:0] mdl_sel;
  logic       exp_bclk = 1'b0;
  bit         mdl_en  = 1'b0;

  always @(posedge clk) begin
    mdl_sel = bif.baudrate;
    cyc++;
    if (reset) begin
      since    = 0;
      exp_bclk = 1'b0;
      cur_d    = div_of(mdl_sel);
      mdl_en   = 1'b1;
    end else if (mdl_sel != prev_sel) begin
      since    = 0;
      exp_bclk = 1'b0;
      cur_d    = div_of(mdl_sel);
    end else begin
      since++;
`ifdef BAUD_BCLK_SQUARE_EN
      exp_bclk = ((since % cur_d) < ((cur_d + 1) / 2));
`else
      exp_bclk = ((since % cur_d) == 0);
`endif
    end
    prev_sel = mdl_sel;
    #1;
    if (mdl_en) chk("bclk_model", 32'(bif.bclk), 32'(exp_bclk));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.bclk === 1'b1) begin
        at = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_pulse: no bclk pulse within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (bif.bclk === lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int r_edge, e_edge, at, last, n;

  initial begin
    bif.baudrate = BAUD_19200;
    reset = 1'b1;
    tick(3);
    chk("reset_bclk_low", 32'(bif.bclk), 0);

`ifdef BAUD_BCLK_SQUARE_EN
    bif.baudrate = BAUD_230400;
    tick(3);
    chk("sq_reset_low", 32'(bif.bclk), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("sq_rise_after_release", 32'(bif.bclk), 1);
    run_len(1'b1, n); chk("sq_first_high", n, 13);
    run_len(1'b0, n); chk("sq_low_13", n, 13);
    run_len(1'b1, n); chk("sq_high_14", n, 14);
    run_len(1'b0, n); chk("sq_low_13b", n, 13);
    run_len(1'b1, n); chk("sq_high_14b", n, 14);
`else
    // first pulse D edges after the last reset edge, then 30 steady periods
    r_edge = cyc;
    reset  = 1'b0;
    wait_pulse(1000, at);
    chk("first_pulse_19200", at - r_edge, 326);
    last = at;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("pulse_width_19200", 32'(bif.bclk), 0);
      wait_pulse(1000, at);
      chk("period_19200", at - last, 326);
      last = at;
    end

    // sweep every code, 5 periods each
    for (int c = 0; c < 8; c++) begin
      bif.baudrate = baud_sel_e'(3'(c));
      e_edge = cyc + 1;
      wait_pulse(3000, at);
      chk("sweep_first", at - e_edge, LIT_D[c]);
      last = at;
      for (int p = 0; p < 5; p++) begin
        wait_pulse(3000, at);
        chk("sweep_period", at - last, LIT_D[c]);
        last = at;
      end
    end

    // rate change 011 -> 110 with cnt at 200
    bif.baudrate = BAUD_19200;
    wait_pulse(1000, at);
    tick(200);
    bif.baudrate = BAUD_115200;
    e_edge = cyc + 1;
    @(negedge clk);
    chk("no_pulse_on_change", 32'(bif.bclk), 0);
    wait_pulse(200, at);
    chk("change_first_pulse", at - e_edge, 54);
    last = at;
    for (int p = 0; p < 3; p++) begin
      wait_pulse(200, at);
      chk("change_period", at - last, 54);
      last = at;
    end

    // reset mid-period with 000 selected
    bif.baudrate = BAUD_2400;
    wait_pulse(3000, at);
    tick(1000);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_reset_low", 32'(bif.bclk), 0);
    end
    r_edge = cyc;
    reset  = 1'b0;
    wait_pulse(3000, at);
    chk("post_reset_first", at - r_edge, 2604);
    last = at;

    // re-driving the same code must not restart the counter
    for (int i = 0; i < 5; i++) begin
      tick(100);
      bif.baudrate = BAUD_2400;
    end
    wait_pulse(3000, at);
    chk("same_code_period", at - last, 2604);
`endif

    // randomized rate changes and short resets, checked by the model
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        tick(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      bif.baudrate = baud_sel_e'(3'($urandom_range(0, 7)));
      tick(int'($urandom_range(1, 400)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
